// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU issue controller and its bench-facing users.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_REM  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SRA  = 4'd11,
    OP_SLT  = 4'd12,
    OP_SLTU = 4'd13,
    OP_PASS = 4'd14,
    OP_ZERO = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } issue_state_e;

  // Divide and remainder use operand A as the divisor.
  function automatic logic is_div_by_zero(input logic [OP_W-1:0] op,
                                          input logic [DATA_W-1:0] a);
    return ((op == OP_DIV) || (op == OP_REM)) && (a == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two depth, extra pointer bit separates full from empty,
// head entry is visible combinationally on data_o.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues ALU commands, issues them one at a time to a registered ALU, and returns
// tagged responses in acceptance order; divide/remainder by zero bypass the ALU.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_c,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             rsp_dz,
  output logic             busy
);

  localparam int CMD_W = 4 + 32 + 32 + TAG_W;

  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  logic [3:0]       head_op;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [TAG_W-1:0] head_tag;

  issue_state_e     state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_dz_q, rsp_dz_d;

  assign cmd_ready  = !fifo_full && !reset;
  assign fifo_wdata = {cmd_opcode, cmd_a, cmd_b, cmd_tag};
  assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid && cmd_ready),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_dz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
      rsp_dz_q   <= rsp_dz_d;
    end
  end

  // Operand registers only load on a real issue so the ALU inputs keep their last values.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    rsp_dz_d   = rsp_dz_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_op;
          tag_d    = head_tag;
          if (is_div_by_zero(head_op, head_a)) begin
            rsp_data_d = '0;
            rsp_tag_d  = head_tag;
            rsp_err_d  = 1'b0;
            rsp_dz_d   = 1'b1;
            state_d    = ST_RESP;
          end else begin
            a_d     = head_a;
            b_d     = head_b;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        rsp_data_d = alu_c;
        rsp_tag_d  = tag_q;
        rsp_err_d  = (op_q == OP_ADD) && alu_err;
        rsp_dz_d   = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_opcode = (state_q == ST_ISSUE) ? op_q : OP_HOLD;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_dz     = rsp_dz_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
